// File: rtl/reg_seq_if.sv
// rtl/reg_seq_if.sv - instruction handshake and register-file port bundle for reg_seq
interface reg_seq_if #(
    parameter int DATA_W = 16
);
    logic [15:0]       in_instr;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        rn_1;
    logic [1:0]        rn_2;
    logic [DATA_W-1:0] rd_1;
    logic [DATA_W-1:0] rd_2;
    logic [1:0]        wn;
    logic [DATA_W-1:0] wd;
    logic              w;

    // master: instruction source plus register file; slave: the sequencer
    modport master (
        output in_instr, in_valid, rd_1, rd_2,
        input  in_ready, rn_1, rn_2, wn, wd, w
    );

    modport slave (
        input  in_instr, in_valid, rd_1, rd_2,
        output in_ready, rn_1, rn_2, wn, wd, w
    );
endinterface

// File: rtl/reg_seq.sv
// rtl/reg_seq.sv - four-phase register-to-register instruction sequencer driving reg_block
module reg_seq #(
    parameter int DATA_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    reg_seq_if.slave    bus,
    input  logic        hold,
    output logic        done,
    output logic        flag_z,
    output logic        flag_c
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_MOV = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_LDI = 3'b111;

    state_t            state, state_nx;
    logic              accept;
    logic [2:0]        op_q;
    logic [1:0]        dst_q;
    logic [7:0]        imm_q;
    logic [DATA_W-1:0] opa_q, opb_q;
    logic [DATA_W-1:0] res;
    logic              res_c;
    logic              upd_flags;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // hold freezes every transition and masks the write-back strobes
    always_comb begin
        state_nx     = state;
        accept       = 1'b0;
        bus.in_ready = 1'b0;
        bus.w        = 1'b0;
        done         = 1'b0;
        case (state)
            S_IDLE: begin
                bus.in_ready = rst && !hold;
                accept       = bus.in_ready && bus.in_valid;
                if (accept) state_nx = S_READ;
            end
            S_READ:  if (!hold) state_nx = S_EXEC;
            S_EXEC:  if (!hold) state_nx = S_WRITE;
            S_WRITE: begin
                if (!hold) begin
                    bus.w    = (op_q != OP_NOP);
                    done     = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        res       = opa_q;
        res_c     = 1'b0;
        upd_flags = 1'b0;
        case (op_q)
            OP_MOV: res = opa_q;
            OP_ADD: begin
                {res_c, res} = {1'b0, opa_q} + {1'b0, opb_q};
                upd_flags    = 1'b1;
            end
            OP_SUB: begin
                // the extra top bit of the widened difference is the borrow
                {res_c, res} = {1'b0, opa_q} - {1'b0, opb_q};
                upd_flags    = 1'b1;
            end
            OP_AND: begin res = opa_q & opb_q; upd_flags = 1'b1; end
            OP_OR:  begin res = opa_q | opb_q; upd_flags = 1'b1; end
            OP_XOR: begin res = opa_q ^ opb_q; upd_flags = 1'b1; end
            OP_LDI: res = {{(DATA_W-8){1'b0}}, imm_q};
            default: res = opa_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q     <= OP_NOP;
            dst_q    <= 2'd0;
            imm_q    <= 8'd0;
            opa_q    <= '0;
            opb_q    <= '0;
            bus.rn_1 <= 2'd0;
            bus.rn_2 <= 2'd0;
            bus.wn   <= 2'd0;
            bus.wd   <= '0;
            flag_z   <= 1'b0;
            flag_c   <= 1'b0;
        end else begin
            if (accept) begin
                op_q     <= bus.in_instr[15:13];
                dst_q    <= bus.in_instr[12:11];
                imm_q    <= bus.in_instr[7:0];
                bus.rn_1 <= bus.in_instr[10:9];
                bus.rn_2 <= bus.in_instr[8:7];
            end
            if (state == S_READ && !hold) begin
                opa_q <= bus.rd_1;
                opb_q <= bus.rd_2;
            end
            if (state == S_EXEC && !hold) begin
                bus.wd <= res;
                bus.wn <= dst_q;
                if (upd_flags) begin
                    flag_z <= (res == '0);
                    flag_c <= res_c;
                end
            end
        end
    end
endmodule

// File: tb/tb_reg_seq.sv
// tb/tb_reg_seq.sv - randomized self-checking bench for reg_seq against a behavioural model
module tb_reg_seq;
    logic clk = 1'b0;
    logic rst;
    logic hold;
    logic done;
    logic flag_z, flag_c;

    reg_seq_if #(.DATA_W(16)) bus ();

    reg_seq #(.DATA_W(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .hold   (hold),
        .done   (done),
        .flag_z (flag_z),
        .flag_c (flag_c)
    );

    always #5 clk = ~clk;

    // register file environment (stands in for reg_block)
    logic [15:0] rf [4];
    assign bus.rd_1 = rf[bus.rn_1];
    assign bus.rd_2 = rf[bus.rn_2];
    always @(posedge clk) if (bus.w) rf[bus.wn] <= bus.wd;

    int w_cnt = 0;
    int done_cnt = 0;
    always @(posedge clk) begin
        if (bus.w) w_cnt <= w_cnt + 1;
        if (done)  done_cnt <= done_cnt + 1;
    end

    int n_checks = 0;
    int n_pass = 0;

    // reference model state
    int exp_rf [4];
    int exp_z = 0;
    int exp_c = 0;
    int exp_wcnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] enc(input int op, input int dst, input int ra, input int rb);
        return 16'((op << 13) | (dst << 11) | (ra << 9) | (rb << 7));
    endfunction

    function automatic logic [15:0] ldi(input int dst, input int imm);
        return 16'((7 << 13) | (dst << 11) | (imm & 255));
    endfunction

    task automatic model(input logic [15:0] instr, output logic e_w, output int e_wn, output int e_wd);
        int op, dst, a, b, r;
        op  = int'(instr[15:13]);
        dst = int'(instr[12:11]);
        a   = exp_rf[instr[10:9]];
        b   = exp_rf[instr[8:7]];
        r   = 0;
        case (op)
            1: r = a;
            2: begin r = (a + b) % 65536; exp_c = (a + b >= 65536) ? 1 : 0; end
            3: begin r = (a - b + 65536) % 65536; exp_c = (a < b) ? 1 : 0; end
            4: begin r = a & b; exp_c = 0; end
            5: begin r = a | b; exp_c = 0; end
            6: begin r = a ^ b; exp_c = 0; end
            7: r = int'(instr[7:0]);
            default: r = 0;
        endcase
        if (op >= 2 && op <= 6) exp_z = (r == 0) ? 1 : 0;
        e_w  = (op != 0);
        e_wn = dst;
        e_wd = r;
        if (e_w) begin
            exp_rf[dst] = r;
            exp_wcnt++;
        end
    endtask

    task automatic exec_instr(input logic [15:0] instr, input int hr, input int hw);
        int guard, e_wn, e_wd;
        logic e_w;
        guard = 0;
        while (!bus.in_ready && guard < 12) begin @(negedge clk); guard++; end
        check("idle_ready", bus.in_ready, 1);
        model(instr, e_w, e_wn, e_wd);
        bus.in_instr = instr;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_instr = 16'($urandom);
        check("rn_1", bus.rn_1, instr[10:9]);
        check("rn_2", bus.rn_2, instr[8:7]);
        check("read_ready", bus.in_ready, 0);
        if (hr > 0) begin
            hold = 1'b1;
            repeat (hr) begin #1; check("hold_read_strobe", {bus.w, done}, 0); @(negedge clk); end
            hold = 1'b0;
        end
        @(negedge clk);
        check("exec_ready", bus.in_ready, 0);
        check("exec_strobe", {bus.w, done}, 0);
        @(negedge clk);
        if (hw > 0) begin
            hold = 1'b1;
            repeat (hw) begin #1; check("hold_write_strobe", {bus.w, done}, 0); @(negedge clk); end
            hold = 1'b0;
        end
        #1;
        check("done", done, 1);
        check("w", bus.w, e_w);
        check("write_ready", bus.in_ready, 0);
        if (e_w) begin
            check("wn", bus.wn, e_wn);
            check("wd", bus.wd, e_wd);
        end
        check("flag_z", flag_z, exp_z);
        check("flag_c", flag_c, exp_c);
        @(negedge clk);
        check("retire_ready", bus.in_ready, 1);
        check("retire_done", done, 0);
    endtask

    task automatic check_rf(input string tag);
        for (int i = 0; i < 4; i++) check(tag, rf[i], exp_rf[i]);
    endtask

    initial begin
        int n_acc, last, d0, wc0, guard;
        int e_wn, e_wd;
        logic e_w;
        for (int i = 0; i < 4; i++) begin rf[i] = 16'd0; exp_rf[i] = 0; end
        rst = 1'b0;
        hold = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_instr = 16'd0;
        #1;
        check("rst_ready", bus.in_ready, 0);
        check("rst_strobe", {bus.w, done}, 0);
        check("rst_regs", {bus.rn_1, bus.rn_2, bus.wn, bus.wd, flag_z, flag_c}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_rst_ready", bus.in_ready, 1);
        @(negedge clk);

        exec_instr(ldi(2, 15), 0, 0);
        exec_instr(ldi(0, 100), 0, 0);
        exec_instr(enc(2, 1, 0, 2), 0, 0);
        check("add_r1", rf[1], 115);
        exec_instr(enc(3, 3, 2, 0), 0, 0);
        check("sub_r3", rf[3], 16'hFFAB);
        check("sub_borrow", flag_c, 1);

        exec_instr(ldi(0, 0), 0, 0);
        exec_instr(ldi(2, 1), 0, 0);
        exec_instr(enc(3, 0, 0, 2), 0, 0);
        exec_instr(enc(2, 1, 0, 2), 0, 0);
        check("wrap_z_c", {flag_z, flag_c}, 2'b11);
        exec_instr(enc(6, 1, 1, 1), 0, 0);
        check("xor_z_c", {flag_z, flag_c}, 2'b10);
        exec_instr(enc(1, 3, 0, 0), 0, 0);
        check("mov_r3", rf[3], 16'hFFFF);
        check("mov_flags", {flag_z, flag_c}, 2'b10);

        exec_instr(enc(2, 2, 3, 2), 3, 2);
        check_rf("rf_after_hold");

        // hold in IDLE blocks acceptance
        hold = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_instr = ldi(1, 9);
        repeat (2) begin #1; check("hold_idle_ready", bus.in_ready, 0); @(negedge clk); end
        bus.in_valid = 1'b0;
        hold = 1'b0;
        #1;
        check("hold_idle_no_accept", bus.in_ready, 1);
        @(negedge clk);

        exec_instr(ldi(1, 1), 0, 0);
        d0 = done_cnt;
        n_acc = 0;
        last = -1;
        bus.in_instr = enc(2, 1, 1, 1);
        bus.in_valid = 1'b1;
        for (int cyc = 0; cyc < 40 && n_acc < 3; cyc++) begin
            if (bus.in_ready) begin
                if (last >= 0) check("b2b_gap", cyc - last, 4);
                last = cyc;
                n_acc++;
                model(enc(2, 1, 1, 1), e_w, e_wn, e_wd);
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("b2b_accepts", n_acc, 3);
        guard = 0;
        while (!bus.in_ready && guard < 10) begin @(negedge clk); guard++; end
        check("b2b_r1", rf[1], 8);
        check("b2b_dones", done_cnt - d0, 3);

        // reset in EXEC discards the in-flight LDI
        wc0 = w_cnt;
        bus.in_instr = ldi(3, 55);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_ready", bus.in_ready, 0);
        check("arst_strobe", {bus.w, done}, 0);
        check("arst_regs", {bus.rn_1, bus.rn_2, bus.wn, bus.wd, flag_z, flag_c}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        exp_z = 0;
        exp_c = 0;
        #1;
        check("arst_release_ready", bus.in_ready, 1);
        check("arst_no_write", w_cnt - wc0, 0);
        check("arst_r3", rf[3], exp_rf[3]);
        @(negedge clk);

        for (int k = 0; k < 24; k++) begin
            logic [15:0] ins;
            ins = 16'($urandom);
            exec_instr(ins, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end
        check_rf("rf_final");
        check("write_count", w_cnt, exp_wcnt);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/reg_seq.md
Name: reg_seq

Overview:
- Multi-cycle sequencer that executes one register-to-register instruction at a time against reg_block, the 4 x 16-bit register file.
- Register file ports: two combinational read ports and one write port, written on the clock edge while w=1.
- Accepts a 16-bit instruction over a valid/ready handshake, then drives rn_1/rn_2 and captures rd_1/rd_2. Computes the result, then drives wn/wd/w for exactly one cycle of write-back.
- Sits between the instruction source and reg_block; it is the only master of the register file's ports.

Parameters:
DATA_W, 16, datapath width; must equal the reg_block data width.

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  asynchronous active-low reset
in_instr  input  16  instruction word
in_valid  input  1  in_instr is valid
in_ready  output  1  sequencer can accept an instruction (high only in IDLE)
hold  input  1  stall; freezes the FSM in its current state
rn_1  output  2  register file read address A
rn_2  output  2  register file read address B
rd_1  input  DATA_W  read data A from the register file
rd_2  input  DATA_W  read data B from the register file
wn  output  2  write address
wd  output  DATA_W  write data
w  output  1  write enable
done  output  1  one-cycle pulse when the instruction retires
flag_z  output  1  zero flag
flag_c  output  1  carry/borrow flag

Behaviour:
- Instruction fields:
  - op = [15:13], dst = [12:11], ra = [10:9], rb = [8:7], imm8 = [7:0] (LDI only).
  - imm8 is zero-extended to DATA_W.
- Opcodes:
  - 000 NOP
  - 001 MOV: dst = ra
  - 010 ADD: dst = ra + rb
  - 011 SUB: dst = ra - rb
  - 100 AND
  - 101 OR
  - 110 XOR
  - 111 LDI: dst = imm8
- FSM states:
  - IDLE: in_ready=1. On in_valid & !hold, latch the instruction; rn_1 = ra and rn_2 = rb are registered at this edge. Go to READ.
  - READ: rd_1 and rd_2 are valid during this cycle; capture them into operand registers at the edge. Go to EXEC.
  - EXEC: compute the result and next flags into registers at the edge; wd and wn = dst are registered at this edge. Go to WRITE.
  - WRITE: w=1 (0 for NOP) and done=1 for this single cycle. Go to IDLE.
- Latency and throughput:
  - Accept at edge N: READ occupies cycle N+1, EXEC N+2, WRITE N+3, and in_ready=1 again in cycle N+4.
  - Throughput is one instruction per 4 cycles.
  - Back-to-back dependent instructions need no forwarding: the next READ is always at least one edge after the previous write.
- hold:
  - While hold=1 the state, operand, result and flag registers do not change, and w=0 and done=0 are forced.
  - In IDLE with hold=1, in_ready=0 and the instruction is not accepted.
  - If hold rises in WRITE, the write and done occur in the first cycle with hold=0. A write is never duplicated or dropped.
- in_valid outside IDLE is ignored (in_ready=0). in_instr need be stable only at the accept edge.
- Arithmetic:
  - ADD: flag_c = carry out of the DATA_W+1-bit sum.
  - SUB: flag_c = borrow, i.e. 1 iff ra < rb unsigned. The result wraps modulo 2^DATA_W.
  - AND/OR/XOR: flag_c = 0.
  - flag_z = (result == 0) for ADD, SUB, AND, OR, XOR.
  - MOV, LDI and NOP leave both flags unchanged.
  - Flags become visible in the WRITE cycle and hold until the next flag-updating instruction.
- Register aliasing: ra == rb, dst == ra, and dst == rb are all legal. Operands are captured before the write, so the old values are used.
- Reset (rst=0, asynchronous, any state including mid-instruction):
  - Immediately forces state IDLE.
  - w=0, done=0, in_ready=0 while rst=0, then 1 after release.
  - rn_1=0, rn_2=0, wn=0, wd=0, flag_z=0, flag_c=0.
  - An instruction in flight is discarded with no write.

Test Plan:
- Reset, then LDI r2,15; LDI r0,100 -> w pulses once per instruction with wn=2/wd=15 and wn=0/wd=100; done coincides with w; in_ready low for exactly 3 cycles after each accept.
- Registers r0=100, r2=15; ADD r1=r0+r2 then SUB r3=r2-r0 -> r1=115 with flag_c=0, flag_z=0; r3=65451 (0xFFAB) with flag_c=1.
- r0=0xFFFF, r2=1; ADD r1=r0+r2 -> r1=0, flag_z=1, flag_c=1. Then XOR r1=r1^r1 -> r1=0, flag_z=1, flag_c=0. Then MOV r3=r0 -> r3=0xFFFF with flags unchanged.
- hold=1 asserted during READ for 3 cycles and again during WRITE for 2 cycles -> outputs frozen; exactly one w pulse, delayed by 5 cycles total; correct data written.
- in_valid held high continuously with 3 queued instructions (ADD r1=r1+r1 three times starting from r1=1) -> instructions accepted every 4 cycles; final r1=8; no instruction accepted while busy.
- rst driven low during EXEC of LDI r3,55 -> w never asserts; r3 keeps its prior value; all outputs 0 asynchronously; normal operation resumes one cycle after release.
